mp_add_seq: RTL and testbench



---
 rtl/mp_add_seq.sv | 196 +++++++++++++++++++
 tb/tb_mp_add_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// +----------------------------------------------------------------------------+
// | Module      : mp_add_seq                                                   |
// | Description : Multi-precision add/subtract sequencer. A single 16-bit      |
// |               carry-look-ahead slice is reused one word per cycle (LSW     |
// |               first) to build a 16*WORDS-bit result plus ALU flags.        |
// |               Optional macro MP_ADD_BYPASS_EN lets DONE accept the next    |
// |               operation straight into RUN on the output handshake.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   result,
  output logic                  sign,
  output logic                  zero,
  output logic                  carry,
  output logic                  parity,
  output logic                  overflow,
  output logic                  busy
);

  localparam int              W      = 16 * WORDS;
  localparam int              IDXW   = $clog2(WORDS);
  localparam logic [IDXW-1:0] C_LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             cin_q, cin_d;
  logic [W-1:0]     result_q, result_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             parity_q, parity_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;

  logic             w_in_ready;
  logic             w_load;
  logic [15:0]      w_x, w_y, w_s;
  logic [15:0]      w_p, w_g, w_bc;
  logic [3:0]       w_gp, w_gg;
  logic [4:0]       w_gc;

  assign w_x = a_q[{idx_q, 4'b0000} +: 16];
  assign w_y = b_q[{idx_q, 4'b0000} +: 16];
  assign w_p = w_x ^ w_y;
  assign w_g = w_x & w_y;

  // Per-group propagate/generate and in-group bit carries from the group carry-in.
  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign w_gp[k] = &w_p[4*k +: 4];
    assign w_gg[k] = w_g[4*k+3]
                   | (w_p[4*k+3] & w_g[4*k+2])
                   | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                   | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    assign w_bc[4*k]   = w_gc[k];
    assign w_bc[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
    assign w_bc[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    assign w_bc[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
  end

  assign w_gc[0] = cin_q;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & cin_q);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin_q);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & cin_q);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin_q);
  assign w_s     = w_p ^ w_bc;

`ifdef MP_ADD_BYPASS_EN
  assign w_in_ready = ~rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
`else
  assign w_in_ready = ~rst & (state_q == S_IDLE);
`endif
  assign w_load = in_valid & w_in_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    result_d    = result_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    parity_d    = parity_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        result_d[{idx_q, 4'b0000} +: 16] = w_s;
        cin_d = w_gc[4];
        if (idx_q == C_LAST) begin
          idx_d       = '0;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          sign_d      = result_d[W-1];
          zero_d      = ~|result_d;
          parity_d    = ~^result_d;
          carry_d     = w_gc[4];
          overflow_d  = (a_q[W-1] & b_q[W-1] & ~result_d[W-1])
                      | (~a_q[W-1] & ~b_q[W-1] & result_d[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Acceptance from IDLE, or from DONE when the bypass path is built in.
    if (w_load) begin
      a_d         = a;
      b_d         = op_sub ? ~b : b;
      cin_d       = op_sub;
      idx_d       = '0;
      out_valid_d = 1'b0;
      state_d     = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      result_q    <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      parity_q    <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      result_q    <= result_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      parity_q    <= parity_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sign      = sign_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign parity    = parity_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mp_add_seq.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_mp_add_seq                                                |
// | Description : Directed bench for mp_add_seq (WORDS=4) with a queue-based   |
// |               scoreboard; honours MP_ADD_BYPASS_EN for spacing checks.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mp_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;
`ifdef MP_ADD_BYPASS_EN
  localparam int SPACING = WORDS + 1;
`else
  localparam int SPACING = WORDS + 2;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, op_sub, out_ready;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, sign, zero, carry, parity, overflow, busy;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] r;
    logic c, z, s, p, v;
    int   acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   have_acc = 0;
  bit   spacing_on = 0;
  bit   ov_prev = 0;

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sign(sign), .zero(zero), .carry(carry), .parity(parity),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int acc);
    exp_t         e;
    logic [W-1:0] bp;
    logic [W:0]   s;
    bp    = sub ? ~y : y;
    s     = {1'b0, x} + {1'b0, bp} + (W+1)'(sub);
    e.r   = s[W-1:0];
    e.c   = s[W];
    e.z   = (s[W-1:0] == '0);
    e.s   = s[W-1];
    e.p   = ~^s[W-1:0];
    e.v   = (x[W-1] & bp[W-1] & ~s[W-1]) | (~x[W-1] & ~bp[W-1] & s[W-1]);
    e.acc = acc;
    return e;
  endfunction

  // Scoreboard: push at acceptance, pop and compare at the output handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && !ov_prev && sb.size() != 0)
        chk("latency", W'(cyc - sb[0].acc), W'(WORDS));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", W'(sb.size()), W'(1));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result",   result,   e.r);
          chk("carry",    W'(carry),    W'(e.c));
          chk("zero",     W'(zero),     W'(e.z));
          chk("sign",     W'(sign),     W'(e.s));
          chk("parity",   W'(parity),   W'(e.p));
          chk("overflow", W'(overflow), W'(e.v));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(op_sub, a, b, cyc + 1));
        if (spacing_on && have_acc)
          chk("spacing", W'(cyc + 1 - last_acc), W'(SPACING));
        last_acc = cyc + 1;
        have_acc = 1'b1;
      end
    end
    ov_prev = out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("tmo_in_ready", W'(in_ready), W'(1));
  endtask

  task automatic issue(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y);
    a = x; b = y; op_sub = sub; in_valid = 1'b1;
    wait_in_ready();
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("tmo_out_valid", W'(out_valid), W'(1));
  endtask

  initial begin
    logic [W-1:0] hold_r;
    logic [4:0]   hold_f;
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result",    result, '0);
    chk("rst_flags",     W'({sign, zero, carry, parity, overflow}), W'(0));
    chk("rst_busy",      W'(busy), W'(0));
    chk("rst_in_ready",  W'(in_ready), W'(0));
    rst = 1'b0;
    #1;
    chk("idle_in_ready", W'(in_ready), W'(1));

    // Word carry, full wrap to zero, signed overflow on subtract.
    issue(1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
    wait_out(); step();
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    wait_out(); step();
    issue(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_out(); step();

    // Back-pressure in DONE while inputs wiggle.
    out_ready = 1'b0;
    issue(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    wait_out();
    hold_r = result;
    hold_f = {sign, zero, carry, parity, overflow};
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op_sub = ~op_sub;
      step();
      chk("hold_result",    result, hold_r);
      chk("hold_flags",     W'({sign, zero, carry, parity, overflow}), W'(hold_f));
      chk("hold_in_ready",  W'(in_ready), W'(0));
      chk("hold_out_valid", W'(out_valid), W'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_out_valid", W'(out_valid), W'(0));
    chk("release_busy",      W'(busy), W'(0));

    // Reset in the middle of RUN at idx=2.
    issue(1'b0, 64'h5555_5555_5555_5555, 64'h1111_1111_1111_1111);
    step(); step();
    rst = 1'b1;
    step();
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_result",    result, '0);
    chk("midrst_flags",     W'({sign, zero, carry, parity, overflow}), W'(0));
    chk("midrst_busy",      W'(busy), W'(0));
    chk("midrst_in_ready",  W'(in_ready), W'(0));
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", W'(in_ready), W'(1));
    issue(1'b0, 64'h1, 64'h1);
    wait_out();
    chk("postrst_sum", result, 64'h2);
    step();

    // Streaming with in_valid held high and alternating add/sub.
    have_acc = 1'b0;
    spacing_on = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      b = (i == 2) ? a : {$urandom, $urandom};
      op_sub = i[0];
      wait_in_ready();
      step();
    end
    in_valid = 1'b0;
    wait_out();
    step(); step();
    spacing_on = 1'b0;
    chk("sb_drained", W'(sb.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
